// File: rtl/calc_arbiter_if.sv
// Request/response channels between the two requester front-ends and calc_arbiter.
// master = requester side, slave = arbiter side.
interface calc_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req0_a;
    logic [2:0] req0_b;
    logic       req0_op;
    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] req1_a;
    logic [2:0] req1_b;
    logic       req1_op;
    logic       rsp0_valid;
    logic       rsp0_ready;
    logic       rsp1_valid;
    logic       rsp1_ready;
    logic [3:0] rsp_r;
    logic       rsp_zero;
    logic       rsp_sign;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_r, rsp_zero, rsp_sign
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_r, rsp_zero, rsp_sign
    );
endinterface

// File: rtl/calc_arbiter.sv
// Two-requester arbiter in front of a single 3-bit sign-magnitude add/sub datapath.
// Define CALC_FIXED_PRIO_EN for fixed priority (req0 wins ties); default is round robin.
module calc_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    calc_arbiter_if.slave    bus,
    output logic [2:0]       dp_a,
    output logic [2:0]       dp_b,
    output logic             dp_o,
    input  logic [3:0]       dp_r,
    input  logic             dp_zero,
    input  logic             dp_sign,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       grant;
    logic       any_req;
    logic       accept;
    logic       capture;
    logic       rsp_hs;
    logic       owner;
    logic       rdy0;
    logic       rdy1;
    logic       rsp0_vld;
    logic       rsp1_vld;
    logic [3:0] rsp_r_q;
    logic       rsp_zero_q;
    logic       rsp_sign_q;

    assign any_req = bus.req0_valid | bus.req1_valid;

`ifdef CALC_FIXED_PRIO_EN
    // req0 wins whenever it is asking; req1 only gets a turn when req0 is idle.
    always_comb begin
        grant = ~bus.req0_valid;
    end
`else
    logic rr_last;

    // rr_last holds the last owner served; resets to 1 so req0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)
            rr_last <= 1'b1;
        else if (rsp_hs)
            rr_last <= owner;
    end

    always_comb begin
        if (bus.req0_valid && bus.req1_valid)
            grant = ~rr_last;
        else
            grant = ~bus.req0_valid;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_hs    = 1'b0;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    accept    = 1'b1;
                    rdy0      = ~grant;
                    rdy1      = grant;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                // Only the owner's ready counts; the other requester's ready is ignored.
                if ((owner && rsp1_vld && bus.rsp1_ready) ||
                    (!owner && rsp0_vld && bus.rsp0_ready)) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control: owner, response valids, completed-operation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= 1'b0;
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;
            op_cnt   <= '0;
        end else begin
            if (accept)
                owner <= grant;
            if (capture) begin
                rsp0_vld <= ~owner;
                rsp1_vld <= owner;
            end
            if (rsp_hs) begin
                rsp0_vld <= 1'b0;
                rsp1_vld <= 1'b0;
                op_cnt   <= op_cnt + 1'b1;
            end
        end
    end

    // Operand registers feeding the datapath, loaded on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_a <= 3'b000;
            dp_b <= 3'b000;
            dp_o <= 1'b0;
        end else if (accept) begin
            dp_a <= grant ? bus.req1_a  : bus.req0_a;
            dp_b <= grant ? bus.req1_b  : bus.req0_b;
            dp_o <= grant ? bus.req1_op : bus.req0_op;
        end
    end

    // Result registers, captured once the datapath has settled for a full cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_r_q    <= 4'b0000;
            rsp_zero_q <= 1'b0;
            rsp_sign_q <= 1'b0;
        end else if (capture) begin
            rsp_r_q    <= dp_r;
            rsp_zero_q <= dp_zero;
            rsp_sign_q <= dp_sign;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp0_valid = rsp0_vld;
    assign bus.rsp1_valid = rsp1_vld;
    assign bus.rsp_r      = rsp_r_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_sign   = rsp_sign_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a behavioural add/sub datapath and a response scoreboard.
module tb_calc_arbiter;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       dp_a;
    logic [2:0]       dp_b;
    logic             dp_o;
    logic [3:0]       dp_r;
    logic             dp_zero;
    logic             dp_sign;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    always #5 clk = ~clk;

    calc_arbiter_if bus ();

    calc_arbiter #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .dp_a    (dp_a),
        .dp_b    (dp_b),
        .dp_o    (dp_o),
        .dp_r    (dp_r),
        .dp_zero (dp_zero),
        .dp_sign (dp_sign),
        .busy    (busy),
        .op_cnt  (op_cnt)
    );

    typedef struct packed {
        logic       id;
        logic [3:0] r;
        logic       zero;
        logic       sign;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   exp_cnt = 0;
`ifdef CALC_FIXED_PRIO_EN
    int   exp_grant[4] = '{0, 0, 0, 0};
`else
    int   exp_grant[4] = '{0, 1, 0, 1};
`endif

    // Sign-magnitude add/sub: returns {zero, sign, r[3:0]}; -0 operands count as zero.
    function automatic logic [5:0] addsub(input logic [2:0] a, input logic [2:0] b, input logic op);
        int va;
        int vb;
        int res;
        int mag;
        va  = a[2] ? -int'(a[1:0]) : int'(a[1:0]);
        vb  = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
        res = op ? (va - vb) : (va + vb);
        mag = (res < 0) ? -res : res;
        return {(mag == 0), (res < 0), (res < 0), mag[2:0]};
    endfunction

    always_comb begin
        {dp_zero, dp_sign, dp_r} = addsub(dp_a, dp_b, dp_o);
    end

    function automatic exp_t mk(input logic id, input logic [2:0] a, input logic [2:0] b, input logic op);
        logic [5:0] m;
        exp_t       e;
        m      = addsub(a, b, op);
        e.id   = id;
        e.r    = m[3:0];
        e.zero = m[5];
        e.sign = m[4];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.req0_valid && bus.req0_ready) begin
                chk("ready_onehot", bus.req1_ready, 1'b0);
                sb.push_back(mk(1'b0, bus.req0_a, bus.req0_b, bus.req0_op));
            end
            if (bus.req1_valid && bus.req1_ready)
                sb.push_back(mk(1'b1, bus.req1_a, bus.req1_b, bus.req1_op));
            if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_id",   bus.rsp1_valid, e.id);
                    chk("sb_r",    bus.rsp_r,      e.r);
                    chk("sb_zero", bus.rsp_zero,   e.zero);
                    chk("sb_sign", bus.rsp_sign,   e.sign);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic drive(input int id, input logic v, input logic [2:0] a, input logic [2:0] b, input logic op);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rspv(input int id);
        return (id == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    task automatic wait_ready(input int id, input string tag);
        int n = 0;
        look();
        while (!rdy(id) && n < 8) begin
            step();
            look();
            n++;
        end
        chk(tag, rdy(id), 1'b1);
    endtask

    task automatic run_op(input int id, input logic [2:0] a, input logic [2:0] b, input logic op,
                          input logic [3:0] er, input logic ez, input logic es);
        step();
        drive(id, 1'b1, a, b, op);
        wait_ready(id, "accept");
        step();
        drive(id, 1'b0, a, b, op);
        look();
        chk("exec_busy", busy, 1'b1);
        chk("exec_rspv", rspv(id), 1'b0);
        chk("dp_a", dp_a, a);
        chk("dp_b", dp_b, b);
        chk("dp_o", dp_o, op);
        step();
        look();
        chk("rspv", rspv(id), 1'b1);
        chk("rspv_other", rspv(1 - id), 1'b0);
        chk("rsp_r", bus.rsp_r, er);
        chk("rsp_zero", bus.rsp_zero, ez);
        chk("rsp_sign", bus.rsp_sign, es);
        step();
        exp_cnt++;
        look();
        chk("rspv_drop", rspv(id), 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("op_cnt", op_cnt, exp_cnt);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int g;
        rst = 1'b1;
        drive(0, 1'b0, 3'b000, 3'b000, 1'b0);
        drive(1, 1'b0, 3'b000, 3'b000, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        step();
        step();
        look();
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy0", bus.req0_ready, 1'b0);
        chk("rst_rdy1", bus.req1_ready, 1'b0);
        chk("rst_rspv0", bus.rsp0_valid, 1'b0);
        chk("rst_rspv1", bus.rsp1_valid, 1'b0);
        chk("rst_rsp", {bus.rsp_r, bus.rsp_zero, bus.rsp_sign}, 6'b0);
        chk("rst_dp", {dp_a, dp_b, dp_o}, 7'b0);
        chk("rst_cnt", op_cnt, 0);
        step();
        rst = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Single operations, including -0 operand and the extreme negative result
        run_op(0, 3'b011, 3'b010, 1'b0, 4'b0101, 1'b0, 1'b0);
        run_op(1, 3'b001, 3'b011, 1'b1, 4'b1010, 1'b0, 1'b1);
        run_op(0, 3'b010, 3'b010, 1'b1, 4'b0000, 1'b1, 1'b0);
        run_op(1, 3'b100, 3'b000, 1'b0, 4'b0000, 1'b1, 1'b0);
        run_op(0, 3'b111, 3'b011, 1'b1, 4'b1110, 1'b0, 1'b1);

        // Both requesters held valid from reset: tie-break order
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        drive(0, 1'b1, 3'b001, 3'b001, 1'b0);
        drive(1, 1'b1, 3'b011, 3'b011, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            look();
            while (!(bus.req0_ready || bus.req1_ready) && n < 8) begin
                step();
                look();
                n++;
            end
            g = bus.req1_ready ? 1 : 0;
            chk("grant_order", g, exp_grant[k]);
            step();
            step();
            look();
            chk("tie_rspv", rspv(g), 1'b1);
            step();
            exp_cnt++;
        end
        drive(0, 1'b0, 3'b001, 3'b001, 1'b0);
        drive(1, 1'b0, 3'b011, 3'b011, 1'b0);
        look();
        chk("tie_cnt", op_cnt, exp_cnt);

        // Stalled response with the other requester waiting
        bus.rsp0_ready = 1'b0;
        step();
        drive(0, 1'b1, 3'b010, 3'b001, 1'b0);
        wait_ready(0, "stall_accept");
        step();
        drive(0, 1'b0, 3'b010, 3'b001, 1'b0);
        drive(1, 1'b1, 3'b001, 3'b001, 1'b1);
        step();
        look();
        chk("stall_rspv_first", bus.rsp0_valid, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step();
            look();
            chk("stall_rspv", bus.rsp0_valid, 1'b1);
            chk("stall_r", bus.rsp_r, 4'b0011);
            chk("stall_rdy1", bus.req1_ready, 1'b0);
        end
        step();
        bus.rsp0_ready = 1'b1;
        look();
        chk("stall_release", bus.rsp0_valid, 1'b1);
        step();
        exp_cnt++;
        look();
        chk("wait_rdy1", bus.req1_ready, 1'b1);
        chk("stall_cnt", op_cnt, exp_cnt);
        step();
        drive(1, 1'b0, 3'b001, 3'b001, 1'b1);
        look();
        chk("req1_exec_rspv", bus.rsp1_valid, 1'b0);
        step();
        look();
        chk("req1_rspv", bus.rsp1_valid, 1'b1);
        chk("req1_r", bus.rsp_r, 4'b0000);
        chk("req1_zero", bus.rsp_zero, 1'b1);
        step();
        exp_cnt++;
        look();
        chk("req1_done", bus.rsp1_valid, 1'b0);
        chk("req1_cnt", op_cnt, exp_cnt);

        // Reset while in EXEC aborts the transaction
        step();
        drive(0, 1'b1, 3'b011, 3'b011, 1'b0);
        wait_ready(0, "abort_accept");
        step();
        drive(0, 1'b0, 3'b011, 3'b011, 1'b0);
        rst = 1'b1;
        look();
        chk("abort_exec_busy", busy, 1'b1);
        step();
        rst = 1'b0;
        look();
        chk("abort_busy", busy, 1'b0);
        chk("abort_rspv0", bus.rsp0_valid, 1'b0);
        chk("abort_rspv1", bus.rsp1_valid, 1'b0);
        chk("abort_cnt", op_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            look();
            chk("abort_no_rsp", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
        end
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
